// File: rtl/lot_occupancy_scheduler.sv
// Shared car-counter scheduler: queues per-lane entry/exit pulses, serves one
// event every two cycles (exits first, round-robin within each class), drives
// the counter's inc/dec, grants or denies entries against lot capacity and
// tracks a shadow occupancy.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | pick next event (exit class first), register its pulses
// S_ISSUE | pulses are on the wires; retire pending, update occupancy
module lot_occupancy_scheduler #(
   parameter int LANES    = 4,
   parameter int CAPACITY = 9,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] entry_req,
   input  logic [LANES-1:0] exit_req,
   output logic             inc,
   output logic             dec,
   output logic [LANES-1:0] entry_grant,
   output logic [LANES-1:0] entry_deny,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             err_overflow,
   output logic             err_underflow
);

   localparam int LW = $clog2(LANES);
   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       pend_entry [LANES];
   logic [1:0]       pend_exit  [LANES];
   logic [LW-1:0]    rr_entry, rr_exit;
   logic [LW-1:0]    sel_lane, sel_lane_nxt;
   logic             sel_exit, sel_exit_nxt;
   logic             inc_nxt, dec_nxt;
   logic [LANES-1:0] grant_nxt, deny_nxt;
   logic [LANES-1:0] entry_nz, exit_nz;
   logic [LANES-1:0] srv_entry, srv_exit;
   logic [LANES-1:0] sat_entry, sat_exit;
   logic             any_entry, any_exit;
   logic [LW-1:0]    entry_pick, exit_pick;
   logic             drop;

   // First nonzero lane at or after ptr, wrapping; msb is the found flag.
   function automatic logic [LW:0] rr_pick(input logic [LANES-1:0] nz,
                                           input logic [LW-1:0] ptr);
      logic          found;
      logic [LW-1:0] pick;
      int            idx;
      found = 1'b0;
      pick  = ptr;
      for (int k = 0; k < LANES; k++) begin
         idx = int'(ptr) + k;
         if (idx >= LANES) idx = idx - LANES;
         if (!found && nz[idx]) begin
            found = 1'b1;
            pick  = LW'(idx);
         end
      end
      return {found, pick};
   endfunction

   // 2-bit saturating queue depth; simultaneous request and service cancel.
   function automatic logic [1:0] pend_step(input logic [1:0] cnt,
                                            input logic req, input logic srv);
      if (req && !srv && cnt != 2'd3) return cnt + 2'd1;
      if (srv && !req)                return cnt - 2'd1;
      return cnt;
   endfunction

   function automatic logic [LW-1:0] lane_next(input logic [LW-1:0] lane);
      return (lane == LW'(LANES - 1)) ? '0 : lane + LW'(1);
   endfunction

   // Per-lane queue status and which queue the current ISSUE retires.
   always_comb begin
      entry_nz  = '0;
      exit_nz   = '0;
      srv_entry = '0;
      srv_exit  = '0;
      sat_entry = '0;
      sat_exit  = '0;
      for (int i = 0; i < LANES; i++) begin
         entry_nz[i]  = (pend_entry[i] != 2'd0);
         exit_nz[i]   = (pend_exit[i]  != 2'd0);
         sat_entry[i] = (pend_entry[i] == 2'd3);
         sat_exit[i]  = (pend_exit[i]  == 2'd3);
         srv_entry[i] = (state == S_ISSUE) && !sel_exit && (sel_lane == LW'(i));
         srv_exit[i]  = (state == S_ISSUE) &&  sel_exit && (sel_lane == LW'(i));
      end
      drop = (|(entry_req & ~srv_entry & sat_entry)) |
             (|(exit_req  & ~srv_exit  & sat_exit));
      {any_entry, entry_pick} = rr_pick(entry_nz, rr_entry);
      {any_exit,  exit_pick}  = rr_pick(exit_nz,  rr_exit);
   end

   // Next state and next-cycle pulses; occupancy is stable until ISSUE ends,
   // so the grant/deny decision can be made while still in IDLE.
   always_comb begin
      state_nxt    = state;
      sel_lane_nxt = sel_lane;
      sel_exit_nxt = sel_exit;
      inc_nxt      = 1'b0;
      dec_nxt      = 1'b0;
      grant_nxt    = '0;
      deny_nxt     = '0;
      case (state)
         S_IDLE: begin
            if (any_exit) begin
               state_nxt    = S_ISSUE;
               sel_exit_nxt = 1'b1;
               sel_lane_nxt = exit_pick;
               dec_nxt      = (occupancy != '0);
            end else if (any_entry) begin
               state_nxt    = S_ISSUE;
               sel_exit_nxt = 1'b0;
               sel_lane_nxt = entry_pick;
               if (occupancy < CAP) begin
                  inc_nxt               = 1'b1;
                  grant_nxt[entry_pick] = 1'b1;
               end else begin
                  deny_nxt[entry_pick]  = 1'b1;
               end
            end
         end
         S_ISSUE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, selection and registered output pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         sel_lane    <= '0;
         sel_exit    <= 1'b0;
         inc         <= 1'b0;
         dec         <= 1'b0;
         entry_grant <= '0;
         entry_deny  <= '0;
      end else begin
         state       <= state_nxt;
         sel_lane    <= sel_lane_nxt;
         sel_exit    <= sel_exit_nxt;
         inc         <= inc_nxt;
         dec         <= dec_nxt;
         entry_grant <= grant_nxt;
         entry_deny  <= deny_nxt;
      end
   end

   // Pending request queues.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) begin
            pend_entry[i] <= 2'd0;
            pend_exit[i]  <= 2'd0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            pend_entry[i] <= pend_step(pend_entry[i], entry_req[i], srv_entry[i]);
            pend_exit[i]  <= pend_step(pend_exit[i],  exit_req[i],  srv_exit[i]);
         end
      end
   end

   // Occupancy, round-robin pointers and sticky errors, retired at end of ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         occupancy     <= '0;
         rr_entry      <= '0;
         rr_exit       <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (drop) err_overflow <= 1'b1;
         if (state == S_ISSUE) begin
            if (sel_exit) begin
               rr_exit <= lane_next(sel_lane);
               if (occupancy != '0) occupancy     <= occupancy - CNT_W'(1);
               else                 err_underflow <= 1'b1;
            end else begin
               rr_entry <= lane_next(sel_lane);
               if (occupancy < CAP) occupancy <= occupancy + CNT_W'(1);
            end
         end
      end
   end

   assign full  = (occupancy == CAP);
   assign empty = (occupancy == '0);

endmodule

// File: tb/tb_lot_occupancy_scheduler.sv
// Directed bench for lot_occupancy_scheduler with hand-computed expectations.
module tb_lot_occupancy_scheduler;

   logic       clk;
   logic       reset;
   logic [3:0] entry_req, exit_req;
   logic       inc, dec;
   logic [3:0] entry_grant, entry_deny;
   logic [3:0] occupancy;
   logic       full, empty, err_overflow, err_underflow;

   int checks   = 0;
   int failures = 0;
   int inc_cnt  = 0;
   int dec_cnt  = 0;
   int g0_cnt   = 0;
   int viol     = 0;
   int base_inc, base_dec, base_g0;

   lot_occupancy_scheduler #(.LANES(4), .CAPACITY(9), .CNT_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .entry_req     (entry_req),
      .exit_req      (exit_req),
      .inc           (inc),
      .dec           (dec),
      .entry_grant   (entry_grant),
      .entry_deny    (entry_deny),
      .occupancy     (occupancy),
      .full          (full),
      .empty         (empty),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse tallies and exclusivity, sampled mid-cycle.
   always @(negedge clk) begin
      if (inc) inc_cnt++;
      if (dec) dec_cnt++;
      if (entry_grant[0]) g0_cnt++;
      if (inc && dec) viol++;
      if ($countones(entry_grant | entry_deny) > 1) viol++;
      if ((entry_grant | entry_deny) != 4'b0 && !inc && entry_grant != 4'b0) viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Drive one request cycle; returns at the start of cycle 1.
   task automatic pulse(input logic [3:0] en, input logic [3:0] ex);
      entry_req = en;
      exit_req  = ex;
      tick();
      entry_req = 4'b0;
      exit_req  = 4'b0;
   endtask

   initial begin
      reset     = 1'b1;
      entry_req = 4'b0;
      exit_req  = 4'b0;
      repeat (2) tick();
      chk("rst_occ",   occupancy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full",  full, 0);
      chk("rst_inc",   inc, 0);
      chk("rst_dec",   dec, 0);
      chk("rst_errs",  {err_overflow, err_underflow}, 0);
      reset = 1'b0;

      // single entry
      pulse(4'b0001, 4'b0000);
      tick();
      chk("t1_inc",   inc, 1);
      chk("t1_grant", entry_grant, 4'b0001);
      chk("t1_dec",   dec, 0);
      tick();
      chk("t1_occ",   occupancy, 1);
      chk("t1_empty", empty, 0);
      chk("t1_inc_off", inc, 0);

      // simultaneous entries from zero
      do_reset();
      pulse(4'b1111, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t2_inc",   inc, 1);
         chk("t2_grant", entry_grant, 32'(4'b0001 << k));
         tick();
         chk("t2_gap",   inc, 0);
      end
      chk("t2_occ", occupancy, 4);

      // exit priority at occupancy 5
      pulse(4'b0001, 4'b0000);
      repeat (2) tick();
      chk("t3_pre_occ", occupancy, 5);
      pulse(4'b0010, 4'b0100);
      tick();
      chk("t3_dec_first", dec, 1);
      chk("t3_no_inc",    inc, 0);
      tick();
      chk("t3_mid_occ",   occupancy, 4);
      tick();
      chk("t3_inc_second", inc, 1);
      chk("t3_grant",      entry_grant, 4'b0010);
      tick();
      chk("t3_occ", occupancy, 5);

      // capacity
      pulse(4'b1111, 4'b0000);
      repeat (8) tick();
      chk("t4_occ_full", occupancy, 9);
      chk("t4_full",     full, 1);
      pulse(4'b0001, 4'b0000);
      tick();
      chk("t4_deny",     entry_deny, 4'b0001);
      chk("t4_no_inc",   inc, 0);
      chk("t4_no_grant", entry_grant, 0);
      tick();
      chk("t4_occ_stay", occupancy, 9);
      pulse(4'b0000, 4'b0001);
      tick();
      chk("t4_dec", dec, 1);
      tick();
      chk("t4_occ_8",   occupancy, 8);
      chk("t4_full_off", full, 0);

      // exit at empty
      do_reset();
      pulse(4'b0000, 4'b1000);
      tick();
      chk("t5_no_dec", dec, 0);
      tick();
      chk("t5_underflow", err_underflow, 1);
      chk("t5_occ",       occupancy, 0);
      chk("t5_empty",     empty, 1);
      chk("t5_no_ovf",    err_overflow, 0);

      // queue overflow while exits keep the scheduler busy
      do_reset();
      base_inc = inc_cnt;
      base_dec = dec_cnt;
      base_g0  = g0_cnt;
      exit_req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         entry_req = 4'b0001;
         if (k == 3) chk("t5_ovf_before", err_overflow, 0);
         tick();
         exit_req = 4'b0000;
      end
      entry_req = 4'b0000;
      chk("t5_overflow", err_overflow, 1);
      repeat (16) tick();
      chk("t5_inc_count", inc_cnt - base_inc, 3);
      chk("t5_g0_count",  g0_cnt - base_g0, 3);
      chk("t5_dec_count", dec_cnt - base_dec, 0);
      chk("t5_occ_3",     occupancy, 3);
      chk("t5_uf_sticky", err_underflow, 1);

      // reset in the cycle inc is high, with a second entry still queued
      do_reset();
      entry_req = 4'b0001;
      tick();
      tick();
      entry_req = 4'b0000;
      chk("t6_inc", inc, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_occ",   occupancy, 0);
      chk("t6_inc_off", inc, 0);
      chk("t6_empty", empty, 1);
      base_inc = inc_cnt;
      base_dec = dec_cnt;
      repeat (8) tick();
      chk("t6_no_pulses", (inc_cnt - base_inc) + (dec_cnt - base_dec), 0);
      chk("t6_occ_end",   occupancy, 0);

      chk("exclusive", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
